alu_rs: RTL and testbench

- Reservation station feeding the integer ALU.
- Accepts renamed ALU ops from dispatch and tracks operand readiness by snooping writeback broadcasts.
- Issues the oldest fully-ready entry to the ALU over the issue_en / issue_entry / ready handshake; the PRF read for rs1_data/rs2_data is driven from issue_entry.prs1/prs2 in the same cycle.
- Sits between rename/dispatch and the alu block; flushes on branch mispredict.

---
 rtl/ooo_types.sv | 36 +++
 rtl/rs_select.sv | 29 ++
 rtl/alu_rs.sv | 139 +++++++++++++
 tb/tb_alu_rs.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/ooo_types.sv
// ============================================================================
// Module      : ooo_types
// Description : Shared out-of-order core types: ALU op encodings and the
//               reservation-station entry record.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ooo_types;

  localparam int PHYS_REG_BITS = 7;
  localparam int ROB_BITS      = 4;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef struct packed {
    alu_op_e                  alu_op;
    logic                     alu_src;
    logic [31:0]              immediate;
    logic [PHYS_REG_BITS-1:0] prs1;
    logic [PHYS_REG_BITS-1:0] prs2;
    logic                     rs1_ready;
    logic                     rs2_ready;
    logic [PHYS_REG_BITS-1:0] prd;
    logic [ROB_BITS-1:0]      rob_tag;
    logic                     reg_write;
  } rs_entry_t;

endpackage

`default_nettype wire

// File: rtl/rs_select.sv
// ============================================================================
// Module      : rs_select
// Description : Combinational lowest-index priority picker (one-hot grant).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_select #(
  parameter int RS_DEPTH = 8
) (
  input  logic [RS_DEPTH-1:0] i_req,
  output logic [RS_DEPTH-1:0] o_grant,
  output logic                o_found
);

  always_comb begin
    o_grant = '0;
    o_found = 1'b0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (i_req[i] && !o_found) begin
        o_grant[i] = 1'b1;
        o_found    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
// Module      : alu_rs
// Description : Compacting ALU reservation station; issues oldest ready entry.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs
  import ooo_types::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int NUM_WB   = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   dispatch_en,
  input  rs_entry_t                              dispatch_entry,
  output logic                                   full,
  output logic                                   empty,
  output logic [$clog2(RS_DEPTH+1)-1:0]          count,
  input  logic [NUM_WB-1:0]                      wb_en,
  input  logic [NUM_WB-1:0][PHYS_REG_BITS-1:0]   wb_prd,
  output logic                                   issue_en,
  output rs_entry_t                              issue_entry,
  input  logic                                   ready,
  input  logic                                   flush
);

  localparam int c_cnt_w = $clog2(RS_DEPTH+1);

  rs_entry_t            r_entries [RS_DEPTH];
  logic [RS_DEPTH-1:0]  r_valid;
  logic [c_cnt_w-1:0]   r_count;

  rs_entry_t            w_woke    [RS_DEPTH+1];
  rs_entry_t            w_next    [RS_DEPTH];
  logic [RS_DEPTH:0]    w_valid_ext;
  logic [RS_DEPTH-1:0]  w_next_valid;
  logic [RS_DEPTH-1:0]  w_req;
  logic [RS_DEPTH-1:0]  w_grant;
  logic                 w_found;
  logic                 w_fire;
  logic                 w_accept;
  logic                 w_seen;
  logic [c_cnt_w-1:0]   w_tail;
  rs_entry_t            w_disp;
  rs_entry_t            w_sel;

  assign count = r_count;
  assign full  = (r_count == c_cnt_w'(RS_DEPTH));
  assign empty = (r_count == '0);

  always_comb begin
    w_req = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_req[i] = r_valid[i] && r_entries[i].rs1_ready && r_entries[i].rs2_ready;
    end
  end

  rs_select #(.RS_DEPTH(RS_DEPTH)) u_select (
    .i_req   (w_req),
    .o_grant (w_grant),
    .o_found (w_found)
  );

  assign w_fire   = w_found && ready && !flush;
  assign w_accept = dispatch_en && !full && !flush;
  assign w_tail   = w_fire ? (r_count - c_cnt_w'(1)) : r_count;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (w_grant[i]) w_sel = r_entries[i];
    end
  end

  assign issue_en    = w_fire;
  assign issue_entry = w_fire ? w_sel : '0;

  // Incoming op: p0 is always ready, and a same-cycle broadcast is captured.
  always_comb begin
    w_disp = dispatch_entry;
    if (dispatch_entry.prs1 == '0) w_disp.rs1_ready = 1'b1;
    if (dispatch_entry.prs2 == '0) w_disp.rs2_ready = 1'b1;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_en[p] && dispatch_entry.prs1 == wb_prd[p]) w_disp.rs1_ready = 1'b1;
      if (wb_en[p] && dispatch_entry.prs2 == wb_prd[p]) w_disp.rs2_ready = 1'b1;
    end
  end

  // Wake in place first, then shift, so a wakeup follows its entry down.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_woke[i] = r_entries[i];
      for (int p = 0; p < NUM_WB; p++) begin
        if (r_valid[i] && wb_en[p] && r_entries[i].prs1 == wb_prd[p]) w_woke[i].rs1_ready = 1'b1;
        if (r_valid[i] && wb_en[p] && r_entries[i].prs2 == wb_prd[p]) w_woke[i].rs2_ready = 1'b1;
      end
    end
    w_woke[RS_DEPTH] = '0;
    w_valid_ext      = {1'b0, r_valid};
  end

  always_comb begin
    w_seen       = 1'b0;
    w_next_valid = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      w_seen          = w_seen | w_grant[i];
      w_next[i]       = w_woke[i];
      w_next_valid[i] = r_valid[i];
      if (w_fire && w_seen) begin
        w_next[i]       = w_woke[i+1];
        w_next_valid[i] = w_valid_ext[i+1];
      end
      if (w_accept && w_tail == c_cnt_w'(i)) begin
        w_next[i]       = w_disp;
        w_next_valid[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
      for (int i = 0; i < RS_DEPTH; i++) r_entries[i] <= '0;
    end else if (flush) begin
      r_valid <= '0;
      r_count <= '0;
    end else begin
      r_valid <= w_next_valid;
      r_count <= r_count + c_cnt_w'(w_accept) - c_cnt_w'(w_fire);
      for (int i = 0; i < RS_DEPTH; i++) r_entries[i] <= w_next[i];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
// Module      : tb_alu_rs
// Description : Directed self-checking bench for the ALU reservation station.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rs;
  import ooo_types::*;

  logic            clk;
  logic            rst;
  logic            dispatch_en;
  rs_entry_t       dispatch_entry;
  logic            full;
  logic            empty;
  logic [3:0]      count;
  logic [1:0]      wb_en;
  logic [1:0][6:0] wb_prd;
  logic            issue_en;
  rs_entry_t       issue_entry;
  logic            ready;
  logic            flush;

  int n_checks = 0;
  int n_fail   = 0;

  alu_rs #(.RS_DEPTH(8), .NUM_WB(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .dispatch_en    (dispatch_en),
    .dispatch_entry (dispatch_entry),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .wb_en          (wb_en),
    .wb_prd         (wb_prd),
    .issue_en       (issue_en),
    .issue_entry    (issue_entry),
    .ready          (ready),
    .flush          (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       d_en;
    logic [6:0] prs1;
    logic [6:0] prs2;
    logic       r1;
    logic       r2;
    logic [6:0] prd;
    logic [3:0] rob;
    logic [1:0] wben;
    logic [6:0] wb0;
    logic [6:0] wb1;
    logic       rdy;
    logic       fl;
    logic       exp_issue;
    logic [6:0] exp_prd;
    logic [3:0] exp_rob;
    int         exp_count;
  } vec_t;

  function automatic vec_t mk(int d_en, int prs1, int prs2, int r1, int r2, int prd, int rob,
                              int wben, int wb0, int wb1, int rdy, int fl,
                              int ei, int eprd, int erob, int ecnt);
    vec_t v;
    v.d_en = 1'(d_en);  v.prs1 = 7'(prs1); v.prs2 = 7'(prs2);
    v.r1   = 1'(r1);    v.r2   = 1'(r2);   v.prd  = 7'(prd);   v.rob = 4'(rob);
    v.wben = 2'(wben);  v.wb0  = 7'(wb0);  v.wb1  = 7'(wb1);
    v.rdy  = 1'(rdy);   v.fl   = 1'(fl);
    v.exp_issue = 1'(ei); v.exp_prd = 7'(eprd); v.exp_rob = 4'(erob); v.exp_count = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    dispatch_en               = v.d_en;
    dispatch_entry            = '0;
    dispatch_entry.alu_op     = ALU_SUB;
    dispatch_entry.immediate  = 32'(v.rob) + 32'd100;
    dispatch_entry.prs1       = v.prs1;
    dispatch_entry.prs2       = v.prs2;
    dispatch_entry.rs1_ready  = v.r1;
    dispatch_entry.rs2_ready  = v.r2;
    dispatch_entry.prd        = v.prd;
    dispatch_entry.rob_tag    = v.rob;
    dispatch_entry.reg_write  = 1'b1;
    wb_en     = v.wben;
    wb_prd[0] = v.wb0;
    wb_prd[1] = v.wb1;
    ready     = v.rdy;
    flush     = v.fl;
    #1;
    chk({tag, " issue_en"}, 64'(issue_en), 64'(v.exp_issue));
    if (v.exp_issue) begin
      chk({tag, " issue prd"}, 64'(issue_entry.prd), 64'(v.exp_prd));
      chk({tag, " issue rob_tag"}, 64'(issue_entry.rob_tag), 64'(v.exp_rob));
    end else begin
      chk({tag, " idle issue_entry"}, 64'(issue_entry), 64'd0);
    end
    @(posedge clk);
    #1;
    chk({tag, " count"}, 64'(count), 64'(v.exp_count));
    chk({tag, " full"},  64'(full),  64'(v.exp_count == 8));
    chk({tag, " empty"}, 64'(empty), 64'(v.exp_count == 0));
  endtask

  vec_t vecs [16];

  initial begin
    // d_en prs1 prs2 r1 r2 prd rob | wben wb0 wb1 rdy fl | ei eprd erob cnt
    vecs[0]  = mk(1,  5,  6, 1, 1, 10, 0,  0,  0,  0, 1, 0,  0,  0, 0, 1);
    vecs[1]  = mk(0,  0,  0, 0, 0,  0, 0,  0,  0,  0, 1, 0,  1, 10, 0, 0);
    vecs[2]  = mk(1, 20,  0, 0, 0, 11, 1,  0,  0,  0, 1, 0,  0,  0, 0, 1);
    vecs[3]  = mk(1,  3,  4, 1, 1, 12, 2,  0,  0,  0, 1, 0,  0,  0, 0, 2);
    vecs[4]  = mk(0,  0,  0, 0, 0,  0, 0,  1, 20,  0, 1, 0,  1, 12, 2, 1);
    vecs[5]  = mk(0,  0,  0, 0, 0,  0, 0,  0,  0,  0, 1, 0,  1, 11, 1, 0);
    vecs[6]  = mk(1,  7,  8, 1, 1, 13, 3,  0,  0,  0, 0, 0,  0,  0, 0, 1);
    vecs[7]  = mk(1, 40, 41, 0, 1, 14, 4,  0,  0,  0, 0, 0,  0,  0, 0, 2);
    vecs[8]  = mk(0,  0,  0, 0, 0,  0, 0,  2,  0, 40, 1, 0,  1, 13, 3, 1);
    vecs[9]  = mk(0,  0,  0, 0, 0,  0, 0,  0,  0,  0, 1, 0,  1, 14, 4, 0);
    vecs[10] = mk(1,  0, 30, 0, 0, 15, 5,  2,  0, 30, 1, 0,  0,  0, 0, 1);
    vecs[11] = mk(0,  0,  0, 0, 0,  0, 0,  0,  0,  0, 1, 0,  1, 15, 5, 0);
    vecs[12] = mk(1, 50, 51, 0, 1, 16, 6,  1, 52,  0, 1, 0,  0,  0, 0, 1);
    vecs[13] = mk(0,  0,  0, 0, 0,  0, 0,  0, 50,  0, 1, 0,  0,  0, 0, 1);
    vecs[14] = mk(0,  0,  0, 0, 0,  0, 0,  1, 50,  0, 1, 0,  0,  0, 0, 1);
    vecs[15] = mk(0,  0,  0, 0, 0,  0, 0,  0,  0,  0, 1, 0,  1, 16, 6, 0);

    rst = 1'b1; dispatch_en = 1'b0; dispatch_entry = '0;
    wb_en = '0; wb_prd = '0; ready = 1'b1; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset count", 64'(count), 64'd0);
    chk("reset full", 64'(full), 64'd0);
    chk("reset empty", 64'(empty), 64'd1);
    chk("reset issue_en", 64'(issue_en), 64'd0);
    chk("reset issue_entry", 64'(issue_entry), 64'd0);

    for (int i = 0; i < 16; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Fill to capacity while the ALU stalls, overflow attempt, then in-order drain.
    for (int i = 0; i < 8; i++)
      step(mk(1, 1, 2, 1, 1, 20 + i, i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1), $sformatf("fill%0d", i));
    step(mk(1, 1, 2, 1, 1, 60, 8, 0, 0, 0, 0, 0, 0, 0, 0, 8), "overflow");
    for (int i = 0; i < 8; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 20 + i, i, 7 - i), $sformatf("drain%0d", i));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "drained");

    // Flush beats a concurrent dispatch and issue.
    for (int i = 0; i < 4; i++)
      step(mk(1, 1, 2, 1, 1, 30 + i, i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1), $sformatf("pre_flush%0d", i));
    step(mk(1, 1, 2, 1, 1, 70, 9, 0, 0, 0, 1, 1, 0, 0, 0, 0), "flush");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "post_flush");

    // Full with issue and dispatch together: the issue wins, the dispatch is dropped.
    for (int i = 0; i < 8; i++)
      step(mk(1, 1, 2, 1, 1, 40 + i, i, 0, 0, 0, 0, 0, 0, 0, 0, i + 1), $sformatf("refill%0d", i));
    step(mk(1, 1, 2, 1, 1, 90, 9, 0, 0, 0, 1, 0, 1, 40, 0, 7), "full_issue_disp");
    for (int i = 1; i < 8; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 40 + i, i, 7 - i), $sformatf("redrain%0d", i));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "dropped_absent");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
